// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter that sequences one shared 32-bit bitwise
// logic unit and returns a registered, ID-tagged result under valid/ready.
module logic_unit_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic [DATA_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] B0,
  input  logic [1:0]            OP0,
  input  logic                  REQ1,
  input  logic [DATA_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] B1,
  input  logic [1:0]            OP1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  RSP_VLD,
  output logic                  RSP_ID,
  input  logic                  RSP_RDY
);

  // state | meaning
  // IDLE  | sample REQ0/REQ1, latch the winner's operands
  // EXEC  | grant pulse to the winner, logic unit evaluates latched operands
  // RESP  | hold RESULT/RSP_ID/RSP_VLD until RSP_RDY

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] opa_q, opb_q;
  logic [1:0]            opc_q;
  logic                  id_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  rsp_vld_q;
  logic                  rsp_id_q;

  logic                  load_ops;
  logic                  load_rsp;
  logic                  clr_vld;
  logic                  win_id;
  logic                  gnt0_c, gnt1_c;
  logic [DATA_WIDTH-1:0] win_a, win_b;
  logic [1:0]            win_op;
  logic [DATA_WIDTH-1:0] lu_out;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_ops = 1'b0;
    load_rsp = 1'b0;
    clr_vld  = 1'b0;
    win_id   = 1'b0;
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie the requester that was not served last wins.
          win_id   = (REQ0 && REQ1) ? ~last_q : REQ1;
          load_ops = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        gnt0_c   = ~id_q;
        gnt1_c   = id_q;
        load_rsp = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (RSP_RDY) begin
          clr_vld = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign win_a  = win_id ? A1  : A0;
  assign win_b  = win_id ? B1  : B0;
  assign win_op = win_id ? OP1 : OP0;

  // The single shared logic unit, fed only from the latched operands.
  always_comb begin
    lu_out = '0;
    case (opc_q)
      OP_AND:  lu_out = opa_q & opb_q;
      OP_OR:   lu_out = opa_q | opb_q;
      OP_NOR:  lu_out = ~(opa_q | opb_q);
      OP_XOR:  lu_out = opa_q ^ opb_q;
      default: lu_out = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opa_q  <= '0;
      opb_q  <= '0;
      opc_q  <= OP_AND;
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else if (load_ops) begin
      opa_q  <= win_a;
      opb_q  <= win_b;
      opc_q  <= win_op;
      id_q   <= win_id;
      last_q <= win_id;
    end
  end

  // RESULT deliberately keeps its value after the response is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_q  <= '0;
      rsp_id_q  <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else if (load_rsp) begin
      result_q  <= lu_out;
      rsp_id_q  <= id_q;
      rsp_vld_q <= 1'b1;
    end else if (clr_vld) begin
      rsp_vld_q <= 1'b0;
    end
  end

  assign GNT0    = gnt0_c;
  assign GNT1    = gnt1_c;
  assign RESULT  = result_q;
  assign RSP_VLD = rsp_vld_q;
  assign RSP_ID  = rsp_id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: a transaction-level model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_logic_unit_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [31:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic [1:0]  OP0 = '0, OP1 = '0;
  logic        GNT0, GNT1;
  logic [31:0] RESULT;
  logic        RSP_VLD, RSP_ID;
  logic        RSP_RDY = 1'b1;

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .A0(A0), .B0(B0), .OP0(OP0),
    .REQ1(REQ1), .A1(A1), .B1(B1), .OP1(OP1),
    .GNT0(GNT0), .GNT1(GNT1),
    .RESULT(RESULT), .RSP_VLD(RSP_VLD), .RSP_ID(RSP_ID), .RSP_RDY(RSP_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  // Transaction model: one operation in flight; grant cycle, then a response
  // that waits for RSP_RDY, then the next sample.
  logic        m_gnt0 = 0, m_gnt1 = 0, m_vld = 0, m_id = 0, m_last = 1;
  logic [31:0] m_res = '0, m_pend = '0;

  always @(posedge CLK or posedge RST) begin
    logic w;
    if (RST) begin
      m_gnt0 = 0; m_gnt1 = 0; m_vld = 0; m_id = 0; m_res = '0; m_last = 1;
    end else if (m_gnt0 || m_gnt1) begin
      m_res = m_pend; m_id = m_gnt1; m_vld = 1;
      m_gnt0 = 0; m_gnt1 = 0;
    end else if (m_vld) begin
      if (RSP_RDY) m_vld = 0;
    end else if (REQ0 || REQ1) begin
      w = (REQ0 && REQ1) ? !m_last : REQ1;
      m_last = w;
      m_pend = w ? lu(OP1, A1, B1) : lu(OP0, A0, B0);
      m_gnt0 = !w; m_gnt1 = w;
    end
  end

  always @(negedge CLK) begin
    chk("cyc_gnt0", {31'd0, GNT0}, {31'd0, m_gnt0});
    chk("cyc_gnt1", {31'd0, GNT1}, {31'd0, m_gnt1});
    chk("cyc_vld", {31'd0, RSP_VLD}, {31'd0, m_vld});
    chk("cyc_id", {31'd0, RSP_ID}, {31'd0, m_id});
    chk("cyc_result", RESULT, m_res);
    chk("cyc_gnt_excl", {31'd0, GNT0 & GNT1}, 32'd0);
    chk("cyc_gnt_vs_vld", {31'd0, (GNT0 | GNT1) & RSP_VLD}, 32'd0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_gnt(input logic who, input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((who ? GNT1 : GNT0) === 1'b1) begin ok = 1; break; end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_any_gnt(output logic who, input string name);
    bit ok = 0;
    who = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (GNT0 === 1'b1 || GNT1 === 1'b1) begin ok = 1; who = GNT1; break; end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_op0(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp, input string name);
    A0 = a; B0 = b; OP0 = op; REQ0 = 1;
    wait_gnt(0, {name, "_gnt"});
    REQ0 = 0;
    tick();
    chk(name, RESULT, exp);
    chk({name, "_id"}, {31'd0, RSP_ID}, 32'd0);
    tick();
  endtask

  initial begin
    logic who;
    repeat (2) tick();
    chk("rst_vld", {31'd0, RSP_VLD}, 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_gnt", {30'd0, GNT1, GNT0}, 32'd0);
    RST = 0;

    // single request
    A0 = 32'hFFFF_FFFF; B0 = 32'h8000_0001; OP0 = 2'b00; REQ0 = 1;
    tick();
    chk("single_gnt0", {31'd0, GNT0}, 32'd1);
    REQ0 = 0;
    tick();
    chk("single_gnt0_off", {31'd0, GNT0}, 32'd0);
    chk("single_vld", {31'd0, RSP_VLD}, 32'd1);
    chk("single_result", RESULT, 32'h8000_0001);
    chk("single_id", {31'd0, RSP_ID}, 32'd0);
    tick();
    chk("single_vld_drop", {31'd0, RSP_VLD}, 32'd0);
    chk("single_result_hold", RESULT, 32'h8000_0001);

    // first tie after reset
    RST = 1; tick(); RST = 0;
    A0 = 1; B0 = 5; OP0 = 2'b00; A1 = 2; B1 = 6; OP1 = 2'b01;
    REQ0 = 1; REQ1 = 1;
    tick();
    chk("tie_gnt0", {30'd0, GNT1, GNT0}, 32'd1);
    REQ0 = 0;
    tick();
    chk("tie_res0", RESULT, 32'h0000_0001);
    chk("tie_id0", {31'd0, RSP_ID}, 32'd0);
    wait_gnt(1, "tie_gnt1");
    REQ1 = 0;
    tick();
    chk("tie_res1", RESULT, 32'h0000_0006);
    chk("tie_id1", {31'd0, RSP_ID}, 32'd1);
    tick();

    // round robin with both requests held
    A0 = 32'h0000_00F0; B0 = 32'h0000_0F0F; OP0 = 2'b11;
    A1 = 32'h1234_5678; B1 = 32'h0F0F_0F0F; OP1 = 2'b10;
    REQ0 = 1; REQ1 = 1;
    for (int i = 0; i < 4; i++) begin
      wait_any_gnt(who, "rr_gnt");
      chk("rr_order", {31'd0, who}, i % 2);
      if (who) begin A1 = A1 + 32'h1111; OP1 = OP1 + 2'd1; end
      else     begin A0 = A0 ^ 32'hA5A5_0000; OP0 = OP0 + 2'd1; end
      if (i == 3) begin REQ0 = 0; REQ1 = 0; end
      tick();
      chk("rr_rsp_id", {31'd0, RSP_ID}, {31'd0, who});
    end
    tick(); tick();

    // opcode coverage
    do_op0(32'h0, 32'h2, 2'b10, 32'hFFFF_FFFD, "op_nor");
    do_op0(32'h6, 32'h2, 2'b11, 32'h0000_0004, "op_xor");
    do_op0(32'hFFFC_017F, 32'h8000_0001, 2'b00, 32'h8000_0001, "op_and");

    // backpressure with requester 1 pending
    RSP_RDY = 0;
    A0 = 6; B0 = 2; OP0 = 2'b11; REQ0 = 1;
    wait_gnt(0, "bp_gnt0");
    REQ0 = 0;
    A1 = 32'hF; B1 = 32'h3; OP1 = 2'b00; REQ1 = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", {31'd0, RSP_VLD}, 32'd1);
      chk("bp_result", RESULT, 32'h4);
      chk("bp_id", {31'd0, RSP_ID}, 32'd0);
      chk("bp_gnt1", {31'd0, GNT1}, 32'd0);
      tick();
    end
    RSP_RDY = 1;
    tick();
    chk("bp_accept_vld", {31'd0, RSP_VLD}, 32'd0);
    chk("bp_accept_gnt1", {31'd0, GNT1}, 32'd0);
    tick();
    chk("bp_late_gnt1", {31'd0, GNT1}, 32'd1);
    REQ1 = 0;
    tick();
    chk("bp_res1", RESULT, 32'h3);
    tick();

    // reset during EXEC
    A0 = 32'hF0F0_F0F0; B0 = 32'h0; OP0 = 2'b01; REQ0 = 1;
    wait_gnt(0, "mr_gnt0");
    REQ0 = 0;
    #2 RST = 1;
    #1;
    chk("mr_gnt", {30'd0, GNT1, GNT0}, 32'd0);
    chk("mr_vld", {31'd0, RSP_VLD}, 32'd0);
    chk("mr_result", RESULT, 32'd0);
    A0 = 32'h3; B0 = 32'h5; OP0 = 2'b11; A1 = 32'h3; B1 = 32'h5; OP1 = 2'b00;
    REQ0 = 1; REQ1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_rsp", {31'd0, RSP_VLD}, 32'd0);
    end
    #2 RST = 0;
    tick();
    chk("mr_after_gnt0", {30'd0, GNT1, GNT0}, 32'd1);
    REQ0 = 0;
    tick();
    chk("mr_after_res", RESULT, 32'h6);
    wait_gnt(1, "mr_after_gnt1");
    REQ1 = 0;
    tick();
    chk("mr_after_res1", RESULT, 32'h1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
